// File: rtl/alu_unit.sv
// RV32I integer / branch-compare execution unit behind the RS ALU issue port.
// Optional RV32M multiply pipeline (2-cycle latency for all ops) under ALU_MUL_EN.
module alu_unit #(
  parameter int ROB_WIDTH     = 4,
  parameter int RS_TYPE_WIDTH = 6
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush,
  input  logic                     alu_en,
  input  logic [RS_TYPE_WIDTH-1:0] alu_type,
  input  logic [ROB_WIDTH-1:0]     alu_rob_id_in,
  input  logic [31:0]              alu_data_j,
  input  logic [31:0]              alu_data_k,
  input  logic [31:0]              alu_imm,
  output logic                     alu_rdy,
  output logic [ROB_WIDTH-1:0]     alu_rob_id_out,
  output logic [31:0]              alu_result
);

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_EQ     = 5'd10,
    OP_NE     = 5'd11,
    OP_GE     = 5'd12,
    OP_GEU    = 5'd13,
    OP_PASSB  = 5'd14,
    OP_ADDPC  = 5'd15,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19
  } alu_op_e;

  alu_op_e     op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_res;

  always_comb begin
    op      = alu_op_e'(alu_type[4:0]);
    op_a    = alu_data_j;
    op_b    = alu_type[5] ? alu_imm : alu_data_k;
    shamt   = op_b[4:0];
    alu_res = '0;
    case (op)
      OP_ADD, OP_ADDPC: alu_res = op_a + op_b;
      OP_SUB:           alu_res = op_a - op_b;
      OP_AND:           alu_res = op_a & op_b;
      OP_OR:            alu_res = op_a | op_b;
      OP_XOR:           alu_res = op_a ^ op_b;
      OP_SLL:           alu_res = op_a << shamt;
      OP_SRL:           alu_res = op_a >> shamt;
      OP_SRA:           alu_res = 32'($signed(op_a) >>> shamt);
      OP_SLT:           alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU:          alu_res = {31'd0, op_a < op_b};
      OP_EQ:            alu_res = {31'd0, op_a == op_b};
      OP_NE:            alu_res = {31'd0, op_a != op_b};
      OP_GE:            alu_res = {31'd0, $signed(op_a) >= $signed(op_b)};
      OP_GEU:           alu_res = {31'd0, op_a >= op_b};
      OP_PASSB:         alu_res = op_b;
      default:          alu_res = '0;
    endcase
  end

  logic                 rdy_q,    rdy_d;
  logic [ROB_WIDTH-1:0] rob_id_q, rob_id_d;
  logic [31:0]          result_q, result_d;

`ifdef ALU_MUL_EN
  // Operands are widened to 33 bits (signedness per opcode) and split into a
  // 17-bit signed high half and a 16-bit low half; four partial products cross
  // the stage boundary and are summed modulo 2^64 in stage 2.
  logic               mul_a_signed;
  logic               mul_b_signed;
  logic [32:0]        a_ext;
  logic [32:0]        b_ext;
  logic signed [16:0] a_lo, a_hi, b_lo, b_hi;
  logic signed [33:0] pp_ll_c, pp_lh_c, pp_hl_c, pp_hh_c;

  always_comb begin
    mul_a_signed = (op == OP_MULH) || (op == OP_MULHSU);
    mul_b_signed = (op == OP_MULH);
    a_ext   = {mul_a_signed & op_a[31], op_a};
    b_ext   = {mul_b_signed & op_b[31], op_b};
    a_lo    = {1'b0, a_ext[15:0]};
    a_hi    = a_ext[32:16];
    b_lo    = {1'b0, b_ext[15:0]};
    b_hi    = b_ext[32:16];
    pp_ll_c = a_lo * b_lo;
    pp_lh_c = a_lo * b_hi;
    pp_hl_c = a_hi * b_lo;
    pp_hh_c = a_hi * b_hi;
  end

  logic                     s1_valid_q, s1_valid_d;
  logic [ROB_WIDTH-1:0]     s1_tag_q,   s1_tag_d;
  logic [31:0]              s1_base_q,  s1_base_d;
  logic                     s1_mul_q,   s1_mul_d;
  logic                     s1_hi_q,    s1_hi_d;
  logic signed [33:0]       pp_ll_q, pp_ll_d, pp_lh_q, pp_lh_d;
  logic signed [33:0]       pp_hl_q, pp_hl_d, pp_hh_q, pp_hh_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_tag_d   = s1_tag_q;
    s1_base_d  = s1_base_q;
    s1_mul_d   = s1_mul_q;
    s1_hi_d    = s1_hi_q;
    pp_ll_d    = pp_ll_q;
    pp_lh_d    = pp_lh_q;
    pp_hl_d    = pp_hl_q;
    pp_hh_d    = pp_hh_q;
    if (rdy_in) begin
      if (flush) begin
        s1_valid_d = 1'b0;
      end else begin
        s1_valid_d = alu_en;
        if (alu_en) begin
          s1_tag_d  = alu_rob_id_in;
          s1_base_d = alu_res;
          s1_mul_d  = (op == OP_MUL) || (op == OP_MULH) ||
                      (op == OP_MULHSU) || (op == OP_MULHU);
          s1_hi_d   = (op != OP_MUL);
          pp_ll_d   = pp_ll_c;
          pp_lh_d   = pp_lh_c;
          pp_hl_d   = pp_hl_c;
          pp_hh_d   = pp_hh_c;
        end
      end
    end
  end

  function automatic logic [63:0] sext64(input logic signed [33:0] v);
    return {{30{v[33]}}, v};
  endfunction

  logic [63:0] prod;
  logic [31:0] stage2_res;

  always_comb begin
    prod = sext64(pp_ll_q) + (sext64(pp_lh_q) << 16) +
           (sext64(pp_hl_q) << 16) + (sext64(pp_hh_q) << 32);
    if (!s1_mul_q)    stage2_res = s1_base_q;
    else if (s1_hi_q) stage2_res = prod[63:32];
    else              stage2_res = prod[31:0];

    rdy_d    = rdy_q;
    rob_id_d = rob_id_q;
    result_d = result_q;
    if (rdy_in) begin
      if (flush) begin
        rdy_d = 1'b0;
      end else begin
        rdy_d = s1_valid_q;
        if (s1_valid_q) begin
          rob_id_d = s1_tag_q;
          result_d = stage2_res;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_base_q  <= '0;
      s1_mul_q   <= 1'b0;
      s1_hi_q    <= 1'b0;
      pp_ll_q    <= '0;
      pp_lh_q    <= '0;
      pp_hl_q    <= '0;
      pp_hh_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      s1_base_q  <= s1_base_d;
      s1_mul_q   <= s1_mul_d;
      s1_hi_q    <= s1_hi_d;
      pp_ll_q    <= pp_ll_d;
      pp_lh_q    <= pp_lh_d;
      pp_hl_q    <= pp_hl_d;
      pp_hh_q    <= pp_hh_d;
    end
  end
`else
  always_comb begin
    rdy_d    = rdy_q;
    rob_id_d = rob_id_q;
    result_d = result_q;
    if (rdy_in) begin
      if (flush) begin
        rdy_d = 1'b0;
      end else begin
        rdy_d = alu_en;
        if (alu_en) begin
          rob_id_d = alu_rob_id_in;
          result_d = alu_res;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rdy_q    <= 1'b0;
      rob_id_q <= '0;
      result_q <= '0;
    end else begin
      rdy_q    <= rdy_d;
      rob_id_q <= rob_id_d;
      result_q <= result_d;
    end
  end

  assign alu_rdy        = rdy_q;
  assign alu_rob_id_out = rob_id_q;
  assign alu_result     = result_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, corner sequences,
// and random traffic against a latency-delay reference model.
module tb_alu_unit;
`ifdef ALU_MUL_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NV = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rdy = 1'b1, fl = 1'b0, en = 1'b0;
  logic [5:0]  typ = '0;
  logic [3:0]  tag_in = '0;
  logic [31:0] a = '0, k = '0, imm = '0;
  logic        out_rdy;
  logic [3:0]  out_tag;
  logic [31:0] out_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_unit #(.ROB_WIDTH(4), .RS_TYPE_WIDTH(6)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush(fl), .alu_en(en),
    .alu_type(typ), .alu_rob_id_in(tag_in), .alu_data_j(a), .alu_data_k(k),
    .alu_imm(imm), .alu_rdy(out_rdy), .alu_rob_id_out(out_tag), .alu_result(out_res)
  );

  function automatic logic [31:0] ref_alu(input logic [5:0] t, input logic [31:0] x,
                                          input logic [31:0] kk, input logic [31:0] im);
    logic [31:0] b;
    longint sa, sb, ub;
    logic [63:0] p;
    b  = t[5] ? im : kk;
    sa = longint'($signed(x));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    p  = '0;
    case (t[4:0])
      5'd0:  return x + b;
      5'd1:  return x - b;
      5'd2:  return x & b;
      5'd3:  return x | b;
      5'd4:  return x ^ b;
      5'd5:  return x << b[4:0];
      5'd6:  return x >> b[4:0];
      5'd7:  return 32'($signed(x) >>> b[4:0]);
      5'd8:  return ($signed(x) < $signed(b)) ? 32'd1 : 32'd0;
      5'd9:  return (x < b) ? 32'd1 : 32'd0;
      5'd10: return (x == b) ? 32'd1 : 32'd0;
      5'd11: return (x != b) ? 32'd1 : 32'd0;
      5'd12: return ($signed(x) >= $signed(b)) ? 32'd1 : 32'd0;
      5'd13: return (x >= b) ? 32'd1 : 32'd0;
      5'd14: return b;
      5'd15: return x + b;
`ifdef ALU_MUL_EN
      5'd16: begin p = 64'(sa * sb); return p[31:0];  end
      5'd17: begin p = 64'(sa * sb); return p[63:32]; end
      5'd18: begin p = 64'(sa * ub); return p[63:32]; end
      5'd19: begin p = {32'd0, x} * {32'd0, b}; return p[63:32]; end
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: a LAT-deep delay line; the last slot is the output channel.
  logic        mv[LAT];
  logic [3:0]  mt[LAT];
  logic [31:0] mr[LAT];
  logic        known;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic e, input logic [5:0] t, input logic [3:0] g,
                      input logic [31:0] x, input logic [31:0] kk, input logic [31:0] im,
                      input logic f, input logic r, input logic rs);
    en = e; typ = t; tag_in = g; a = x; k = kk; imm = im; fl = f; rdy = r; rst = rs;
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < LAT; i++) mv[i] = 1'b0;
      mt[LAT-1] = '0;
      mr[LAT-1] = '0;
      known = 1'b1;
    end else if (r) begin
      if (f) begin
        for (int i = 0; i < LAT; i++) mv[i] = 1'b0;
        known = 1'b0;
      end else begin
        for (int i = LAT - 1; i > 0; i--) begin
          if (mv[i-1]) begin
            mt[i] = mt[i-1];
            mr[i] = mr[i-1];
          end
          mv[i] = mv[i-1];
        end
        if (e) begin
          mt[0] = g;
          mr[0] = ref_alu(t, x, kk, im);
        end
        mv[0] = e;
        if (mv[LAT-1]) known = 1'b1;
      end
    end
    #1;
    chk("model rdy", 32'(out_rdy), 32'(mv[LAT-1]));
    if (known) begin
      chk("model tag", 32'(out_tag), 32'(mt[LAT-1]));
      chk("model result", out_res, mr[LAT-1]);
    end
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic [5:0]  t;
    logic [3:0]  g;
    logic [31:0] a;
    logic [31:0] k;
    logic [31:0] imm;
    logic [31:0] res;
  } vec_t;

  vec_t tbl[NV];

  int seen9, seen10;
  int j;
  logic [31:0] ra, rk, ri;

  initial begin
    for (int i = 0; i < LAT; i++) begin
      mv[i] = 1'b0; mt[i] = '0; mr[i] = '0;
    end
    known = 1'b0;

    tbl[0]  = '{6'h00, 4'd3,  32'd5,          32'd7,          32'd0,          32'd12};
    tbl[1]  = '{6'h01, 4'd1,  32'd0,          32'd1,          32'd0,          32'hFFFF_FFFF};
    tbl[2]  = '{6'h27, 4'd2,  32'h8000_0000,  32'd0,          32'd4,          32'hF800_0000};
    tbl[3]  = '{6'h09, 4'd3,  32'd1,          32'hFFFF_FFFF,  32'd0,          32'd1};
    tbl[4]  = '{6'h0C, 4'd4,  32'hFFFF_FFFF,  32'd0,          32'd0,          32'd0};
    tbl[5]  = '{6'h0D, 4'd5,  32'hFFFF_FFFF,  32'd0,          32'd0,          32'd1};
    tbl[6]  = '{6'h0A, 4'd6,  32'h1234,       32'h1234,       32'd0,          32'd1};
    tbl[7]  = '{6'h19, 4'd7,  32'd9,          32'd9,          32'd0,          32'd0};
    tbl[8]  = '{6'h0B, 4'd8,  32'd1,          32'd2,          32'd0,          32'd1};
    tbl[9]  = '{6'h08, 4'd9,  32'hFFFF_FFFF,  32'd1,          32'd0,          32'd1};
    tbl[10] = '{6'h05, 4'd10, 32'd1,          32'd31,         32'd0,          32'h8000_0000};
    tbl[11] = '{6'h06, 4'd11, 32'h8000_0000,  32'd31,         32'd0,          32'd1};
    tbl[12] = '{6'h2E, 4'd12, 32'd0,          32'd5,          32'hDEAD_B000,  32'hDEAD_B000};
    tbl[13] = '{6'h2F, 4'd13, 32'h0000_1000,  32'd0,          32'hFFFF_FFFC,  32'h0000_0FFC};
    tbl[14] = '{6'h02, 4'd14, 32'h0000_F0F0,  32'h0000_FF00,  32'd0,          32'h0000_F000};
    tbl[15] = '{6'h03, 4'd15, 32'h0000_F0F0,  32'h0000_0F0F,  32'd0,          32'h0000_FFFF};
    tbl[16] = '{6'h04, 4'd0,  32'hFFFF_FFFF,  32'h0F0F_0F0F,  32'd0,          32'hF0F0_F0F0};
    tbl[17] = '{6'h00, 4'd1,  32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0};
`ifdef ALU_MUL_EN
    tbl[18] = '{6'h13, 4'd2,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE};
    tbl[19] = '{6'h10, 4'd3,  32'd7,          32'hFFFF_FFFD,  32'd0,          32'hFFFF_FFEB};
    tbl[20] = '{6'h11, 4'd4,  32'h8000_0000,  32'h8000_0000,  32'd0,          32'h4000_0000};
    tbl[21] = '{6'h12, 4'd5,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF};
`else
    tbl[18] = '{6'h13, 4'd2,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd0};
    tbl[19] = '{6'h10, 4'd3,  32'd7,          32'hFFFF_FFFD,  32'd0,          32'd0};
    tbl[20] = '{6'h11, 4'd4,  32'h8000_0000,  32'h8000_0000,  32'd0,          32'd0};
    tbl[21] = '{6'h12, 4'd5,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd0};
`endif

    step(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    chk("reset rdy", 32'(out_rdy), 32'd0);
    chk("reset tag", 32'(out_tag), 32'd0);
    chk("reset result", out_res, 32'd0);

    // Directed table: single issue, result after LAT edges, one-cycle valid, data held.
    for (int i = 0; i < NV; i++) begin
      step(1'b1, tbl[i].t, tbl[i].g, tbl[i].a, tbl[i].k, tbl[i].imm, 1'b0, 1'b1, 1'b0);
      repeat (LAT - 1) idle();
      chk($sformatf("vec%0d rdy", i), 32'(out_rdy), 32'd1);
      chk($sformatf("vec%0d tag", i), 32'(out_tag), 32'(tbl[i].g));
      chk($sformatf("vec%0d result", i), out_res, tbl[i].res);
      idle();
      chk($sformatf("vec%0d rdy drop", i), 32'(out_rdy), 32'd0);
      chk($sformatf("vec%0d tag hold", i), 32'(out_tag), 32'(tbl[i].g));
      chk($sformatf("vec%0d result hold", i), out_res, tbl[i].res);
    end

    // Back-to-back SUB, SRA(imm), SLTU.
    for (int c = 0; c < 3 + LAT; c++) begin
      if (c < 3)
        step(1'b1, tbl[c+1].t, tbl[c+1].g, tbl[c+1].a, tbl[c+1].k, tbl[c+1].imm, 1'b0, 1'b1, 1'b0);
      else
        idle();
      if (c >= LAT - 1 && c - (LAT - 1) < 3) begin
        j = c - (LAT - 1) + 1;
        chk("b2b rdy", 32'(out_rdy), 32'd1);
        chk("b2b tag", 32'(out_tag), 32'(tbl[j].g));
        chk("b2b result", out_res, tbl[j].res);
      end else if (c >= LAT - 1) begin
        chk("b2b rdy end", 32'(out_rdy), 32'd0);
      end
    end

    // Flush in the result cycle together with a new issue.
    step(1'b1, 6'h00, 4'd5, 32'd10, 32'd20, '0, 1'b0, 1'b1, 1'b0);
    repeat (LAT - 1) idle();
    chk("flush pre rdy", 32'(out_rdy), 32'd1);
    chk("flush pre result", out_res, 32'd30);
    step(1'b1, 6'h00, 4'd6, 32'd1, 32'd1, '0, 1'b1, 1'b1, 1'b0);
    chk("flush rdy", 32'(out_rdy), 32'd0);
    repeat (LAT + 1) begin
      idle();
      chk("flush dropped", 32'(out_rdy), 32'd0);
    end

    // Flush while an operation is still in flight.
    step(1'b1, 6'h00, 4'd7, 32'd3, 32'd4, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    repeat (LAT + 1) begin
      idle();
      chk("midflush dropped", 32'(out_rdy), 32'd0);
    end

    // Freeze straddling an issue.
    seen9 = 0; seen10 = 0;
    step(1'b1, 6'h00, 4'd9, 32'd100, 32'd23, '0, 1'b0, 1'b1, 1'b0);
    if (out_rdy && out_tag == 4'd9) seen9++;
    step(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("freeze rdy", 32'(out_rdy), (LAT == 1) ? 32'd1 : 32'd0);
    step(1'b1, 6'h00, 4'd10, 32'd1, 32'd1, '0, 1'b0, 1'b0, 1'b0);
    chk("freeze rdy2", 32'(out_rdy), (LAT == 1) ? 32'd1 : 32'd0);
    step(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("freeze rdy3", 32'(out_rdy), (LAT == 1) ? 32'd1 : 32'd0);
    repeat (LAT + 1) begin
      idle();
      if (out_rdy && out_tag == 4'd9) begin
        seen9++;
        chk("freeze result", out_res, 32'd123);
      end
      if (out_rdy && out_tag == 4'd10) seen10++;
    end
    chk("freeze once", 32'(seen9), 32'd1);
    chk("freeze not captured", 32'(seen10), 32'd0);

    // Reset mid-operation.
    step(1'b1, 6'h00, 4'd11, 32'd1, 32'd2, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    chk("midreset rdy", 32'(out_rdy), 32'd0);
    chk("midreset tag", 32'(out_tag), 32'd0);
    chk("midreset result", out_res, 32'd0);
    repeat (LAT + 1) begin
      idle();
      chk("midreset dropped", 32'(out_rdy), 32'd0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rk = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      ri = ($urandom_range(0, 3) == 0) ? -32'($urandom_range(0, 3)) : $urandom;
      step($urandom_range(0, 3) != 0, 6'($urandom), 4'($urandom), ra, rk, ri,
           $urandom_range(0, 19) == 0, $urandom_range(0, 6) != 0, $urandom_range(0, 99) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
